// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Packet-level round-robin sharing of one UART TX byte port among
//           NUM_CH requesters, with optional channel-ID header byte.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int         NUM_CH         = 4,
    parameter bit         ADD_HEADER     = 1'b1,
    parameter logic [7:0] HEADER_BASE    = 8'hA0,
    parameter int         TIMEOUT_CYCLES = 2170
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_CH-1:0]   i_req_valid,
    input  logic [8*NUM_CH-1:0] i_req_data,
    input  logic [NUM_CH-1:0]   i_req_last,
    output logic [NUM_CH-1:0]   o_req_ready,
    output logic                o_tx_valid,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_ready,
    output logic [NUM_CH-1:0]   o_grant,
    output logic                o_busy,
    output logic                o_timeout
);

    localparam int c_CH_W  = $clog2(NUM_CH);
    localparam int c_TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMR_W-1:0] c_TMO_LAST =
        (TIMEOUT_CYCLES > 0) ? c_TMR_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [c_CH_W-1:0] c_LAST_CH = c_CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_CH_W-1:0]   grant_q, grant_d;
    logic [c_CH_W-1:0]   rr_q, rr_d;
    logic [c_TMR_W-1:0]  timer_q, timer_d;
    logic                timeout_q, timeout_d;

    logic                w_pick_found;
    logic [c_CH_W-1:0]   w_pick_idx;
    logic [c_CH_W-1:0]   w_next_ch;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [7:0]          w_sel_data;

    assign w_sel_valid = i_req_valid[grant_q];
    assign w_sel_last  = i_req_last[grant_q];
    assign w_sel_data  = i_req_data[8*grant_q +: 8];
    assign w_next_ch   = (grant_q == c_LAST_CH) ? '0 : grant_q + 1'b1;

    // Winner is the valid channel with the smallest distance ahead of rr_q.
    always_comb begin
        int best_off;
        int off;
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        best_off     = NUM_CH;
        off          = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            off = (k - int'(rr_q) + NUM_CH) % NUM_CH;
            if (i_req_valid[k] && (off < best_off)) begin
                best_off     = off;
                w_pick_found = 1'b1;
                w_pick_idx   = c_CH_W'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        timer_d     = timer_q;
        timeout_d   = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_data   = 8'h00;
        o_req_ready = '0;
        o_grant     = '0;
        o_busy      = (state_q != ST_IDLE);
        if (state_q != ST_IDLE) begin
            o_grant[grant_q] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (w_pick_found) begin
                    grant_d = w_pick_idx;
                    state_d = ADD_HEADER ? ST_HEADER : ST_DATA;
                end
            end
            ST_HEADER: begin
                o_tx_valid = 1'b1;
                o_tx_data  = HEADER_BASE | {{(8-c_CH_W){1'b0}}, grant_q};
                if (i_tx_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                o_tx_valid           = w_sel_valid;
                o_tx_data            = w_sel_data;
                o_req_ready[grant_q] = i_tx_ready;
                if (w_sel_valid) begin
                    // A held byte (tx stall) is not idleness, so any valid clears the timer.
                    timer_d = '0;
                    if (i_tx_ready && w_sel_last) begin
                        state_d = ST_IDLE;
                        rr_d    = w_next_ch;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (timer_q == c_TMO_LAST) begin
                        state_d   = ST_IDLE;
                        rr_d      = w_next_ch;
                        timer_d   = '0;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        o_timeout = timeout_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Directed self-checking bench for uart_tx_arbiter (4-ch with header,
//           and 2-ch headerless with timeout disabled).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // 4-channel instance with header and timeout
    logic [3:0]  r_req_valid;
    logic [31:0] r_req_data;
    logic [3:0]  r_req_last;
    logic        r_tx_ready;
    logic [3:0]  w_req_ready;
    logic        w_tx_valid;
    logic [7:0]  w_tx_data;
    logic [3:0]  w_grant;
    logic        w_busy;
    logic        w_timeout;

    // 2-channel headerless instance, timeout disabled
    logic [1:0]  r_b_req_valid;
    logic [15:0] r_b_req_data;
    logic [1:0]  r_b_req_last;
    logic        r_b_tx_ready;
    logic [1:0]  w_b_req_ready;
    logic        w_b_tx_valid;
    logic [7:0]  w_b_tx_data;
    logic [1:0]  w_b_grant;
    logic        w_b_busy;
    logic        w_b_timeout;

    uart_tx_arbiter #(
        .NUM_CH(4), .ADD_HEADER(1'b1), .HEADER_BASE(8'hA0), .TIMEOUT_CYCLES(2170)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(r_req_valid), .i_req_data(r_req_data), .i_req_last(r_req_last),
        .o_req_ready(w_req_ready), .o_tx_valid(w_tx_valid), .o_tx_data(w_tx_data),
        .i_tx_ready(r_tx_ready), .o_grant(w_grant), .o_busy(w_busy), .o_timeout(w_timeout)
    );

    uart_tx_arbiter #(
        .NUM_CH(2), .ADD_HEADER(1'b0), .HEADER_BASE(8'hA0), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(r_b_req_valid), .i_req_data(r_b_req_data), .i_req_last(r_b_req_last),
        .o_req_ready(w_b_req_ready), .o_tx_valid(w_b_tx_valid), .o_tx_data(w_b_tx_data),
        .i_tx_ready(r_b_tx_ready), .o_grant(w_b_grant), .o_busy(w_b_busy), .o_timeout(w_b_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] txq[$];
    logic [7:0] b_txq[$];
    int tmo_cnt   = 0;
    int b_tmo_cnt = 0;

    // Byte log taken mid-cycle: inputs are stable, so this is what the next edge accepts.
    always @(negedge clk) begin
        if (!rst) begin
            if (w_tx_valid && r_tx_ready)     txq.push_back(w_tx_data);
            if (w_b_tx_valid && r_b_tx_ready) b_txq.push_back(w_b_tx_data);
            if (w_timeout)                    tmo_cnt++;
            if (w_b_timeout)                  b_tmo_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-byte packet from an IDLE cycle with channel ch pending; data lane holds 0x30+ch.
    task automatic pkt1(input int ch);
        #1;
        check_val("pkt_idle_gap", {31'd0, w_busy}, 32'd0);
        step(); #1;
        check_val("pkt_grant", {28'd0, w_grant}, 32'(1 << ch));
        check_val("pkt_hdr", {23'd0, w_tx_valid, w_tx_data}, {23'd0, 1'b1, 8'hA0 | ch[7:0]});
        step(); #1;
        check_val("pkt_data", {23'd0, w_tx_valid, w_tx_data}, {23'd0, 1'b1, 8'h30 + ch[7:0]});
        check_val("pkt_ready", {28'd0, w_req_ready}, 32'(1 << ch));
        step();
        r_req_valid[ch] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        int n0;
        rst           = 1'b1;
        r_req_valid   = '0;
        r_req_data    = '0;
        r_req_last    = '0;
        r_tx_ready    = 1'b1;
        r_b_req_valid = '0;
        r_b_req_data  = '0;
        r_b_req_last  = '0;
        r_b_tx_ready  = 1'b1;
        repeat (3) step();
        #1;
        check_val("reset_outs", {w_tx_valid, w_busy, w_timeout, w_grant, w_req_ready, w_tx_data},
                  32'd0);
        rst = 1'b0;
        step();

        // Ch2 two-byte packet with header
        txq.delete();
        r_req_valid[2]     = 1'b1;
        r_req_data[23:16]  = 8'h11;
        r_req_last[2]      = 1'b0;
        #1;
        check_val("t1_idle", {w_tx_valid, w_busy, w_grant, w_req_ready}, 32'd0);
        step(); #1;
        check_val("t1_grant", {28'd0, w_grant}, 32'h4);
        check_val("t1_hdr", {w_tx_valid, w_tx_data}, {1'b1, 8'hA2});
        check_val("t1_hdr_ready", {28'd0, w_req_ready}, 32'h0);
        step(); #1;
        check_val("t1_d0", {w_tx_valid, w_tx_data}, {1'b1, 8'h11});
        check_val("t1_d0_ready", {28'd0, w_req_ready}, 32'h4);
        step();
        r_req_data[23:16] = 8'h22;
        r_req_last[2]     = 1'b1;
        #1;
        check_val("t1_d1", {w_tx_valid, w_tx_data}, {1'b1, 8'h22});
        step();
        r_req_valid[2] = 1'b0;
        #1;
        check_val("t1_back_idle", {w_busy, w_grant}, 32'd0);
        check_val("t1_txlen", txq.size(), 32'd3);
        if (txq.size() == 3) begin
            check_val("t1_tx0", txq[0], 32'hA2);
            check_val("t1_tx1", txq[1], 32'h11);
            check_val("t1_tx2", txq[2], 32'h22);
        end

        // rr_ptr now 3: ch0/ch2/ch3 pending -> order 3, 0, 2
        r_req_data  = 32'h33323130;
        r_req_last  = 4'hF;
        r_req_valid = 4'b1101;
        pkt1(3);
        pkt1(0);
        pkt1(2);

        // After reset rr_ptr=0: ch0/ch1/ch3 pending -> order 0, 1, 3
        rst = 1'b1;
        step();
        rst         = 1'b0;
        r_req_valid = 4'b1011;
        pkt1(0);
        pkt1(1);
        pkt1(3);

        // Ch1 stalled by tx_ready for 5000 cycles mid-packet
        txq.delete();
        tmo_cnt           = 0;
        r_req_valid[1]    = 1'b1;
        r_req_last[1]     = 1'b0;
        r_req_data[15:8]  = 8'h51;
        step(); #1;
        check_val("t3_hdr", w_tx_data, 32'hA1);
        step(); #1;
        check_val("t3_d0", w_tx_data, 32'h51);
        step();
        r_req_data[15:8] = 8'h52;
        r_tx_ready       = 1'b0;
        #1;
        check_val("t3_stall", {w_tx_valid, w_tx_data, w_req_ready}, {1'b1, 8'h52, 4'h0});
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (w_req_ready !== 4'h0 || w_grant !== 4'h2 || w_tx_data !== 8'h52) bad++;
        end
        check_val("t3_stall_hold", bad, 32'd0);
        check_val("t3_no_timeout", tmo_cnt, 32'd0);
        r_tx_ready = 1'b1;
        #1;
        check_val("t3_ready_back", {28'd0, w_req_ready}, 32'h2);
        step();
        r_req_data[15:8] = 8'h53;
        r_req_last[1]    = 1'b1;
        #1;
        check_val("t3_d2", w_tx_data, 32'h53);
        step();
        r_req_valid[1] = 1'b0;
        #1;
        check_val("t3_idle", {31'd0, w_busy}, 32'd0);
        check_val("t3_txlen", txq.size(), 32'd4);
        if (txq.size() == 4) begin
            check_val("t3_stream", {txq[0], txq[1], txq[2], txq[3]}, 32'hA1515253);
        end

        // Ch3 abandons its packet; rr_ptr=2 so ch3 wins, then ch0 after timeout
        tmo_cnt           = 0;
        r_req_valid[3]    = 1'b1;
        r_req_last[3]     = 1'b0;
        r_req_data[31:24] = 8'h77;
        step(); #1;
        check_val("t4_hdr", w_tx_data, 32'hA3);
        step(); #1;
        check_val("t4_d0", {w_tx_valid, w_tx_data}, {1'b1, 8'h77});
        step();
        r_req_valid[3]  = 1'b0;
        r_req_valid[0]  = 1'b1;
        r_req_last[0]   = 1'b1;
        r_req_data[7:0] = 8'h05;
        n = 0;
        while (!w_timeout && n < 3000) begin
            step();
            n++;
        end
        check_val("t4_tmo_latency", n, 32'd2170);
        check_val("t4_tmo_grant", {w_busy, w_grant}, 32'd0);
        step(); #1;
        check_val("t4_tmo_pulse", {31'd0, w_timeout}, 32'd0);
        check_val("t4_next_grant", {28'd0, w_grant}, 32'h1);
        check_val("t4_next_hdr", w_tx_data, 32'hA0);
        step(); #1;
        check_val("t4_next_data", w_tx_data, 32'h05);
        step();
        r_req_valid[0] = 1'b0;
        check_val("t4_tmo_count", tmo_cnt, 32'd1);

        // Reset mid-packet: ch1 (rr_ptr=1) enters DATA, then reset
        r_req_data     = 32'h33323130;
        r_req_last     = 4'h0;
        r_req_valid[1] = 1'b1;
        step(); #1;
        check_val("t5_hdr", w_tx_data, 32'hA1);
        step();
        n0  = txq.size();
        rst = 1'b1;
        step();
        rst         = 1'b0;
        r_req_valid = 4'b0101;
        r_req_last  = 4'hF;
        #1;
        check_val("t5_rst_outs", {w_tx_valid, w_busy, w_timeout, w_grant, w_req_ready, w_tx_data},
                  32'd0);
        check_val("t5_no_drop_byte", txq.size(), n0);
        pkt1(0);
        pkt1(2);

        // 2-channel headerless, timeout disabled: 10000-cycle gap keeps the grant
        r_b_req_valid       = 2'b10;
        r_b_req_data[15:8]  = 8'h9A;
        r_b_req_last        = 2'b00;
        #1;
        check_val("t6_idle", {w_b_busy, w_b_grant}, 32'd0);
        step(); #1;
        check_val("t6_grant", {30'd0, w_b_grant}, 32'h2);
        check_val("t6_d0", {w_b_tx_valid, w_b_tx_data}, {1'b1, 8'h9A});
        check_val("t6_ready", {30'd0, w_b_req_ready}, 32'h2);
        step();
        r_b_req_valid = 2'b00;
        repeat (10000) step();
        #1;
        check_val("t6_held", {w_b_busy, w_b_grant}, {1'b1, 2'b10});
        check_val("t6_no_timeout", b_tmo_cnt, 32'd0);
        r_b_req_valid      = 2'b10;
        r_b_req_data[15:8] = 8'h9B;
        r_b_req_last       = 2'b10;
        #1;
        check_val("t6_d1", {w_b_tx_valid, w_b_tx_data}, {1'b1, 8'h9B});
        step();
        r_b_req_valid = 2'b00;
        #1;
        check_val("t6_idle_end", {w_b_busy, w_b_grant}, 32'd0);
        check_val("t6_txlen", b_txq.size(), 32'd2);
        if (b_txq.size() == 2) begin
            check_val("t6_stream", {b_txq[0], b_txq[1]}, 32'h9A9B);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
